score_accumulator: RTL
======================

SCORE_ACCUMULATOR -- requirements
Module: score_accumulator

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 4, number of gesture classes and weight lanes.
REQ-002 SHALL have parameter NUM_CELLS, default 256, gradient-map cells swept per classification.
REQ-003 SHALL have parameter WEIGHT_BITS, default 8, signed weight width.
REQ-004 SHALL have parameter CELL_BITS, default 8, unsigned cell-value width.
REQ-005 SHALL have parameter ACC_BITS, default 24, signed accumulator width.
REQ-006 SHALL have parameter MARGIN_THRESH, default 64, minimum best-minus-second score for a confident result.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have port start, input, 1, single-cycle request to classify the current map.
REQ-010 SHALL have port busy, output, 1, high from start acceptance until result_valid.
REQ-011 SHALL have port cell_addr, output, $clog2(NUM_CELLS), shared read address to the gradient map and all weight RAMs.
REQ-012 SHALL have port cell_val, input, CELL_BITS, map value, valid one cycle after cell_addr.
REQ-013 SHALL have port w_data, input, NUM_CLASSES*WEIGHT_BITS, packed signed weights (class c at bits [c*WEIGHT_BITS +: WEIGHT_BITS]), valid one cycle after cell_addr.
REQ-014 SHALL have port result_valid, output, 1, one-cycle pulse on completion.
REQ-015 SHALL have port result_class, output, $clog2(NUM_CLASSES), winning class index.
REQ-016 SHALL have port result_score, output, ACC_BITS, winning accumulator value (signed).
REQ-017 SHALL have port result_confident, output, 1, margin check outcome.

Function
REQ-018 SHALL implement FSM IDLE -> SWEEP -> DRAIN -> COMPARE -> DONE -> IDLE.
REQ-019 IDLE: start=1 SHALL clear all accumulators, set cell_addr=0, busy=1, enter SWEEP; start in any other state SHALL be ignored.
REQ-020 SWEEP: cell_addr SHALL increment by 1 per cycle from 0 to NUM_CELLS-1, then the FSM enters DRAIN holding cell_addr.
REQ-021 Each cycle where returned data is valid (SWEEP after its first cycle, plus DRAIN), every lane c SHALL add signed(cell_val zero-extended) * w_data[c] to acc[c].
REQ-022 Accumulation SHALL saturate at +(2^(ACC_BITS-1))-1 and -2^(ACC_BITS-1); no wrap-around.
REQ-023 COMPARE SHALL scan classes 0..NUM_CLASSES-1, one per cycle, tracking best and second-best; ties SHALL resolve to the lower index.
REQ-024 DONE SHALL last one cycle: result_valid=1, busy=0 on the following cycle; results held until the next DONE.
REQ-025 Latency: result_valid SHALL assert exactly NUM_CELLS+NUM_CLASSES+2 cycles after the edge sampling start (262 at defaults).
REQ-026 All-zero map SHALL yield all scores 0, result_class=0.

Reset
REQ-027 rst SHALL force IDLE, busy=0, cell_addr=0, result_valid=0, result_class=0, result_score=0, result_confident=0, accumulators=0.
REQ-028 rst mid-operation SHALL abort without a result_valid pulse; the next start SHALL run a full fresh sweep.

Configuration
REQ-029 Macro SCORE_MARGIN_EN defined: result_confident SHALL be 1 iff (best - second) >= MARGIN_THRESH, computed at ACC_BITS+1 width.
REQ-030 SCORE_MARGIN_EN undefined: second-best tracking SHALL be absent and result_confident SHALL be 1 whenever result_valid fires (0 after reset).

Structure
REQ-031 Shared package gesture_pkg SHALL hold the FSM state enum, class-index type, and class encoding constants (UP=0, DOWN=1, LEFT=2, RIGHT=3).
REQ-032 Sub-module mac_lane SHALL implement one saturating multiply-accumulate lane, instantiated NUM_CLASSES times.

Verification
REQ-033 Map: top 8 rows=10, rest 0; weights UP=+6 top/-4 bottom, others 0 -> result_class=0, score=7680, result_valid at cycle 262.
REQ-034 Map all 255, all weights +127, ACC_BITS=16 -> every acc saturates at 32767, result_class=0 (tie).
REQ-035 Scores UP=500, LEFT=480 with SCORE_MARGIN_EN -> class 0, confident=0; UP=600, LEFT=480 -> confident=1.
REQ-036 start pulsed again at cycle 50 of SWEEP -> ignored, one result_valid only, cycle 262.
REQ-037 rst asserted at cycle 100 of SWEEP, then start -> no pulse from aborted run; fresh result at 262 cycles after new start.

Source files
------------

// File: rtl/gesture_pkg.sv
// Shared types for the gesture score accumulator: FSM states,
// class-index type and gesture class encodings.
package gesture_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  typedef logic [1:0] class_idx_t;

  localparam class_idx_t CLS_UP    = 2'd0;
  localparam class_idx_t CLS_DOWN  = 2'd1;
  localparam class_idx_t CLS_LEFT  = 2'd2;
  localparam class_idx_t CLS_RIGHT = 2'd3;

endpackage

// File: rtl/mac_lane.sv
// One saturating multiply-accumulate lane: acc += zext(cell) * weight.
// Ports: clk, rst (async high), clr_i, en_i, cell_i, weight_i, acc_o.
module mac_lane #(
  parameter int CELL_BITS   = 8,
  parameter int WEIGHT_BITS = 8,
  parameter int ACC_BITS    = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_i,
  input  logic                          en_i,
  input  logic [CELL_BITS-1:0]          cell_i,
  input  logic signed [WEIGHT_BITS-1:0] weight_i,
  output logic signed [ACC_BITS-1:0]    acc_o
);

  // Product width holds the zero-extended cell times a signed weight.
  // Sum is one bit wider than either addend so overflow is visible.
  localparam int PW = CELL_BITS + WEIGHT_BITS + 1;
  localparam int SW = ((ACC_BITS > PW) ? ACC_BITS : PW) + 1;

  localparam logic signed [SW-1:0] MAX_S =
    {{(SW-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S =
    {{(SW-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};

  logic signed [PW-1:0]       cell_s;
  logic signed [PW-1:0]       wt_s;
  logic signed [PW-1:0]       prod;
  logic signed [SW-1:0]       sum;
  logic signed [ACC_BITS-1:0] acc_q;
  logic signed [ACC_BITS-1:0] acc_d;

  always_comb begin
    cell_s = PW'({1'b0, cell_i});
    wt_s   = PW'(weight_i);
    prod   = cell_s * wt_s;
    sum    = SW'(acc_q) + SW'(prod);
    if (sum > MAX_S) begin
      acc_d = MAX_S[ACC_BITS-1:0];
    end else if (sum < MIN_S) begin
      acc_d = MIN_S[ACC_BITS-1:0];
    end else begin
      acc_d = sum[ACC_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/score_accumulator.sv
// Gesture classifier back end: sweeps a gradient map against per-class
// weight RAMs, accumulates saturating scores, then picks the best class.
// Ports: clk, rst (async high), start, busy, cell_addr, cell_val, w_data,
//        result_valid, result_class, result_score, result_confident.
// Option: define SCORE_MARGIN_EN to track the second-best score and
//         report confidence as (best - second) >= MARGIN_THRESH.
module score_accumulator #(
  parameter int NUM_CLASSES   = 4,
  parameter int NUM_CELLS     = 256,
  parameter int WEIGHT_BITS   = 8,
  parameter int CELL_BITS     = 8,
  parameter int ACC_BITS      = 24,
  parameter int MARGIN_THRESH = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic [$clog2(NUM_CELLS)-1:0]        cell_addr,
  input  logic [CELL_BITS-1:0]                cell_val,
  input  logic [NUM_CLASSES*WEIGHT_BITS-1:0]  w_data,
  output logic                                result_valid,
  output logic [$clog2(NUM_CLASSES)-1:0]      result_class,
  output logic signed [ACC_BITS-1:0]          result_score,
  output logic                                result_confident
);

  import gesture_pkg::*;

  localparam int AW = $clog2(NUM_CELLS);
  localparam int CW = $clog2(NUM_CLASSES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_CELLS - 1);
  localparam logic [CW-1:0] LAST_CLS  = CW'(NUM_CLASSES - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] idx_q;

  logic acc_clr;
  logic acc_en;
  logic scan;
  logic load;

  logic signed [ACC_BITS-1:0] acc [NUM_CLASSES];
  logic signed [ACC_BITS-1:0] cur;
  logic signed [ACC_BITS-1:0] best_q;
  logic [CW-1:0]              best_idx_q;

  logic                       valid_q;
  logic [CW-1:0]              res_class_q;
  logic signed [ACC_BITS-1:0] res_score_q;
  logic                       conf_q;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
    mac_lane #(
      .CELL_BITS   (CELL_BITS),
      .WEIGHT_BITS (WEIGHT_BITS),
      .ACC_BITS    (ACC_BITS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (acc_clr),
      .en_i     (acc_en),
      .cell_i   (cell_val),
      .weight_i (w_data[c*WEIGHT_BITS +: WEIGHT_BITS]),
      .acc_o    (acc[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          addr_d  = '0;
        end
      end
      S_SWEEP: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN:   state_d = S_COMPARE;
      S_COMPARE: begin
        if (idx_q == LAST_CLS) begin
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Data returns one cycle behind the address, so the first sweep
  // cycle carries nothing and the drain cycle carries the last cell.
  always_comb begin
    busy    = (state_q != S_IDLE);
    acc_clr = (state_q == S_IDLE) && start;
    acc_en  = ((state_q == S_SWEEP) && (addr_q != '0))
              || (state_q == S_DRAIN);
    scan    = (state_q == S_COMPARE);
    load    = (state_q == S_DONE);
  end

  assign cur = acc[idx_q];

`ifdef SCORE_MARGIN_EN
  localparam logic signed [ACC_BITS-1:0] ACC_MIN =
    {1'b1, {(ACC_BITS-1){1'b0}}};
  localparam logic signed [ACC_BITS:0] THRESH =
    (ACC_BITS+1)'(MARGIN_THRESH);

  logic signed [ACC_BITS-1:0] second_q;
  logic signed [ACC_BITS:0]   margin;

  assign margin = (ACC_BITS+1)'(best_q) - (ACC_BITS+1)'(second_q);
`endif

  // Strict greater-than keeps the lower index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
`ifdef SCORE_MARGIN_EN
      second_q   <= '0;
`endif
    end else begin
      if (state_q == S_DRAIN) begin
        idx_q <= '0;
      end else if (scan) begin
        idx_q <= idx_q + 1'b1;
      end
      if (scan) begin
        if ((idx_q == '0) || (cur > best_q)) begin
          best_q     <= cur;
          best_idx_q <= idx_q;
`ifdef SCORE_MARGIN_EN
          second_q   <= (idx_q == '0) ? ACC_MIN : best_q;
        end else if (cur > second_q) begin
          second_q   <= cur;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      res_class_q <= CW'(CLS_UP);
      res_score_q <= '0;
      conf_q      <= 1'b0;
    end else begin
      valid_q <= load;
      if (load) begin
        res_class_q <= best_idx_q;
        res_score_q <= best_q;
`ifdef SCORE_MARGIN_EN
        conf_q      <= (margin >= THRESH);
`else
        conf_q      <= 1'b1;
`endif
      end
    end
  end

  assign cell_addr        = addr_q;
  assign result_valid     = valid_q;
  assign result_class     = res_class_q;
  assign result_score     = res_score_q;
  assign result_confident = conf_q;

endmodule
